traffic_light_fsm: RTL and testbench
====================================

TRAFFIC_LIGHT_FSM -- requirements
Module: traffic_light_fsm

Interface
REQ-001 The block SHALL provide parameter T_BASE, default 6, green interval in seconds.
REQ-002 The block SHALL provide parameter T_EXT, default 3, side-green extension in seconds.
REQ-003 The block SHALL provide parameter T_YEL, default 2, yellow interval in seconds.
REQ-004 The block SHALL provide parameter T_RED, default 1, all-red clearance interval in seconds.
REQ-005 The block SHALL provide parameter T_WALK, default 5, pedestrian interval in seconds; all parameters legal range 1..15.
REQ-006 clk  input  1  single system clock, rising-edge active.
REQ-007 Reset_Sync  input  1  asynchronous, active-low reset.
REQ-008 sensor  input  1  side-street vehicle present, synchronous to clk.
REQ-009 walk_req  input  1  pedestrian request pulse, synchronous to clk.
REQ-010 expired  input  1  timer interval complete, from downstream Timer.
REQ-011 start_timer  output  1  one-cycle timer load/start strobe.
REQ-012 Value  output  4  interval to load, seconds.
REQ-013 main_lights  output  3  {red,yellow,green} main street.
REQ-014 side_lights  output  3  {red,yellow,green} side street.
REQ-015 walk  output  1  pedestrian walk lamp.

Function
REQ-016 States SHALL be MAIN_GREEN, MAIN_YELLOW, RED_1, SIDE_GREEN, SIDE_YELLOW, RED_2, WALK.
REQ-017 On every state entry the block SHALL pulse start_timer high for exactly one cycle, with Value equal to that state's interval in the same cycle.
REQ-018 Value SHALL hold stable from a start_timer pulse until the next pulse.
REQ-019 expired SHALL be ignored in the cycle start_timer is high; a transition occurs on the first later cycle with expired=1.
REQ-020 MAIN_GREEN (Value=T_BASE): on expiry with sensor=1 go MAIN_YELLOW; with sensor=0 stay and re-pulse start_timer with T_BASE.
REQ-021 MAIN_YELLOW (T_YEL) -> RED_1 (T_RED) -> SIDE_GREEN (T_BASE) on expiry.
REQ-022 SIDE_GREEN: on first expiry with sensor=1 re-pulse once with T_EXT; otherwise, or on expiry of the extension, go SIDE_YELLOW.
REQ-023 SIDE_YELLOW (T_YEL) -> RED_2 (T_RED); RED_2 expiry -> WALK if walk pending, else MAIN_GREEN.
REQ-024 WALK (T_WALK): both streets red, walk=1; expiry -> MAIN_GREEN.
REQ-025 Lights SHALL be Moore outputs: exactly one lamp per street lit, non-green street red; walk=1 only in WALK.
REQ-026 walk_req SHALL set a pending flag; flag clears on WALK entry; a request arriving during WALK is held for the next cycle round.
REQ-027 sensor changing mid-interval SHALL have no effect; it is sampled only on the expiry cycle.

Reset
REQ-028 While Reset_Sync=0: state MAIN_GREEN, main_lights=001, side_lights=100, walk=0, start_timer=0, Value=0, walk pending cleared, extension flag cleared.
REQ-029 First rising clk edge after release SHALL produce start_timer=1, Value=T_BASE.
REQ-030 Reset asserted mid-interval SHALL abort immediately to the REQ-028 values, regardless of expired.

Configuration
REQ-031 Macro TLC_WALK_EN defined: WALK state, walk_req latch and walk output as specified.
REQ-032 TLC_WALK_EN undefined: no WALK state or latch, walk_req ignored, walk tied 0, RED_2 always -> MAIN_GREEN.

Structure
REQ-033 State enum, lamp encodings ({R,Y,G} constants) and default interval constants SHALL live in shared package tlc_pkg.
REQ-034 The pedestrian request latch SHALL be sub-module walk_latch (set, clear, pending); the FSM is otherwise a single module.

Verification
REQ-035 Release reset, sensor=0, expired pulses every 8 cycles -> start_timer pulses with Value=6 repeatedly; lights remain main green.
REQ-036 sensor=1 at MAIN_GREEN expiry -> Value sequence 2,1,6,3,2,1,6; main_lights 010 then 100; side green during 6 and 3.
REQ-037 sensor=0 at SIDE_GREEN expiry -> no extension; next Value=2.
REQ-038 walk_req pulse during SIDE_GREEN (TLC_WALK_EN) -> after RED_2, walk=1, Value=5, both streets 100; then MAIN_GREEN Value=6.
REQ-039 expired=1 held during start_timer cycle -> no transition that cycle; transition occurs next cycle.
REQ-040 Reset_Sync low mid-SIDE_YELLOW -> outputs match REQ-028 asynchronously; after release Value=6 with start_timer=1.

Source files
------------

// File: rtl/tlc_pkg.sv
// tlc_pkg: shared state enum, {R,Y,G} lamp encodings and default intervals for traffic_light_fsm.
// The WALK state exists only when TLC_WALK_EN is defined.
package tlc_pkg;

    typedef enum logic [2:0] {
        MAIN_GREEN,
        MAIN_YELLOW,
        RED_1,
        SIDE_GREEN,
        SIDE_YELLOW,
        RED_2
`ifdef TLC_WALK_EN
        , WALK
`endif
    } state_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    localparam int DEF_T_BASE = 6;
    localparam int DEF_T_EXT  = 3;
    localparam int DEF_T_YEL  = 2;
    localparam int DEF_T_RED  = 1;
    localparam int DEF_T_WALK = 5;

    function automatic logic [2:0] lamp(input logic green, input logic yellow);
        return green ? LAMP_GRN : yellow ? LAMP_YEL : LAMP_RED;
    endfunction

endpackage

// File: rtl/walk_latch.sv
// walk_latch: pedestrian request pending flag; a set arriving with clear wins,
// so a request coinciding with WALK entry is carried to the next round.
module walk_latch (
    input  logic clk,
    input  logic Reset_Sync,
    input  logic set,
    input  logic clear,
    output logic pending
);

    always_ff @(posedge clk or negedge Reset_Sync) begin
        if (!Reset_Sync) pending <= 1'b0;
        else if (set)    pending <= 1'b1;
        else if (clear)  pending <= 1'b0;
    end

endmodule

// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm: main/side street controller driving an external interval timer.
// Define TLC_WALK_EN to add the pedestrian WALK phase and walk_req latch.
module traffic_light_fsm
    import tlc_pkg::*;
#(
    parameter int T_BASE = DEF_T_BASE,
    parameter int T_EXT  = DEF_T_EXT,
    parameter int T_YEL  = DEF_T_YEL,
    parameter int T_RED  = DEF_T_RED,
    parameter int T_WALK = DEF_T_WALK
) (
    input  logic       clk,
    input  logic       Reset_Sync,
    input  logic       sensor,
    input  logic       walk_req,
    input  logic       expired,
    output logic       start_timer,
    output logic [3:0] Value,
    output logic [2:0] main_lights,
    output logic [2:0] side_lights,
    output logic       walk
);

    localparam logic [3:0] V_BASE = 4'(T_BASE);
    localparam logic [3:0] V_EXT  = 4'(T_EXT);
    localparam logic [3:0] V_YEL  = 4'(T_YEL);
    localparam logic [3:0] V_RED  = 4'(T_RED);
    localparam logic [3:0] V_WALK = 4'(T_WALK);

    state_t     state_q, state_d;
    logic [3:0] value_q, value_d;
    logic       start_q, start_d;
    logic       armed_q, armed_d;
    logic       ext_q, ext_d;

    function automatic logic [3:0] interval(input state_t s);
        case (s)
            MAIN_GREEN, SIDE_GREEN:  return V_BASE;
            MAIN_YELLOW, SIDE_YELLOW: return V_YEL;
            RED_1, RED_2:            return V_RED;
            default:                 return V_WALK;
        endcase
    endfunction

`ifdef TLC_WALK_EN
    logic walk_pending;

    walk_latch u_walk_latch (
        .clk       (clk),
        .Reset_Sync(Reset_Sync),
        .set       (walk_req),
        .clear     (state_q == RED_2 && state_d == WALK),
        .pending   (walk_pending)
    );

    assign walk = (state_q == WALK);
`else
    logic walk_req_unused;
    assign walk_req_unused = walk_req;
    assign walk = 1'b0;
`endif

    always_ff @(posedge clk or negedge Reset_Sync) begin
        if (!Reset_Sync) begin
            state_q <= MAIN_GREEN;
            value_q <= '0;
            start_q <= 1'b0;
            armed_q <= 1'b0;
            ext_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            start_q <= start_d;
            armed_q <= armed_d;
            ext_q   <= ext_d;
        end
    end

    // armed_q=0 only right after reset: the initial MAIN_GREEN entry still needs its timer load.
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        start_d = 1'b0;
        armed_d = armed_q;
        ext_d   = ext_q;
        if (!armed_q) begin
            start_d = 1'b1;
            value_d = interval(state_q);
            armed_d = 1'b1;
        end else if (!start_q && expired) begin
            start_d = 1'b1;
            case (state_q)
                MAIN_GREEN:  state_d = sensor ? MAIN_YELLOW : MAIN_GREEN;
                MAIN_YELLOW: state_d = RED_1;
                RED_1:       state_d = SIDE_GREEN;
                SIDE_GREEN: begin
                    ext_d   = sensor && !ext_q;
                    state_d = (sensor && !ext_q) ? SIDE_GREEN : SIDE_YELLOW;
                end
                SIDE_YELLOW: state_d = RED_2;
`ifdef TLC_WALK_EN
                RED_2:       state_d = walk_pending ? WALK : MAIN_GREEN;
`else
                RED_2:       state_d = MAIN_GREEN;
`endif
                default:     state_d = MAIN_GREEN;
            endcase
            value_d = ext_d ? V_EXT : interval(state_d);
        end
    end

    assign start_timer = start_q;
    assign Value       = value_q;
    assign main_lights = lamp(state_q == MAIN_GREEN, state_q == MAIN_YELLOW);
    assign side_lights = lamp(state_q == SIDE_GREEN, state_q == SIDE_YELLOW);

endmodule

// File: tb/tb_traffic_light_fsm.sv
// tb_traffic_light_fsm: directed scenarios plus random traffic against a phase-table reference model.
module tb_traffic_light_fsm;

`ifdef TLC_WALK_EN
    localparam bit WALK_EN = 1'b1;
`else
    localparam bit WALK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       Reset_Sync = 1'b0;
    logic       sensor = 1'b0;
    logic       walk_req = 1'b0;
    logic       expired = 1'b0;
    logic       start_timer;
    logic [3:0] Value;
    logic [2:0] main_lights, side_lights;
    logic       walk;

    always #5 clk = ~clk;

    traffic_light_fsm #(.T_BASE(6), .T_EXT(3), .T_YEL(2), .T_RED(1), .T_WALK(5)) dut (
        .clk        (clk),
        .Reset_Sync (Reset_Sync),
        .sensor     (sensor),
        .walk_req   (walk_req),
        .expired    (expired),
        .start_timer(start_timer),
        .Value      (Value),
        .main_lights(main_lights),
        .side_lights(side_lights),
        .walk       (walk)
    );

    int checks = 0;
    int errors = 0;

    // Phases 0..6: MG, MY, R1, SG, SY, R2, WALK
    int         dur[7]      = '{6, 2, 1, 6, 2, 1, 5};
    logic [2:0] main_tab[7] = '{3'b001, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
    logic [2:0] side_tab[7] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b010, 3'b100, 3'b100};

    int ph;
    int m_val;
    bit m_start, m_ext, m_pend, m_fresh;

    int         vals[$];
    logic [2:0] mains[$], sides[$];
    logic       walks[$];

    function automatic void model_reset();
        ph = 0; m_val = 0; m_start = 0; m_ext = 0; m_pend = 0; m_fresh = 1;
    endfunction

    function automatic void model_step(bit s, bit w, bit e);
        int n;
        bit was_start, extn, old_pend;
        n = ph; was_start = m_start; extn = 0; old_pend = m_pend;
        m_start = 0;
        if (m_fresh) begin
            m_start = 1; m_val = dur[ph]; m_fresh = 0;
        end else if (!was_start && e) begin
            m_start = 1;
            case (ph)
                0: n = s ? 1 : 0;
                3: if (s && !m_ext) begin extn = 1; m_ext = 1; end
                   else begin n = 4; m_ext = 0; end
                5: n = (WALK_EN && old_pend) ? 6 : 0;
                6: n = 0;
                default: n = ph + 1;
            endcase
            m_val = extn ? 3 : dur[n];
        end
        if (WALK_EN) m_pend = w ? 1'b1 : ((ph == 5 && n == 6) ? 1'b0 : old_pend);
        ph = n;
    endfunction

    task automatic tick(input bit s, input bit w, input bit e);
        sensor = s; walk_req = w; expired = e;
        @(posedge clk);
        model_step(s, w, e);
        @(negedge clk);
        checks++;
        if (start_timer !== m_start) begin errors++; $display("FAIL start_timer ph=%0d got %b exp %b", ph, start_timer, m_start); end
        checks++;
        if (Value !== 4'(m_val)) begin errors++; $display("FAIL Value ph=%0d got %0d exp %0d", ph, Value, m_val); end
        checks++;
        if (main_lights !== main_tab[ph]) begin errors++; $display("FAIL main_lights ph=%0d got %b exp %b", ph, main_lights, main_tab[ph]); end
        checks++;
        if (side_lights !== side_tab[ph]) begin errors++; $display("FAIL side_lights ph=%0d got %b exp %b", ph, side_lights, side_tab[ph]); end
        checks++;
        if (walk !== (ph == 6)) begin errors++; $display("FAIL walk ph=%0d got %b exp %b", ph, walk, ph == 6); end
        if (start_timer === 1'b1) begin
            vals.push_back(int'(Value)); mains.push_back(main_lights);
            sides.push_back(side_lights); walks.push_back(walk);
        end
    endtask

    task automatic expire(input bit s, input bit w);
        tick(s, w, 1'b1);
        repeat (3) tick(s, 1'b0, 1'b0);
    endtask

    task automatic clear_log();
        vals.delete(); mains.delete(); sides.delete(); walks.delete();
    endtask

    task automatic test_reset();
        Reset_Sync = 1'b0; expired = 1'b1; sensor = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({start_timer, Value, main_lights, side_lights, walk} !== {1'b0, 4'd0, 3'b001, 3'b100, 1'b0}) begin
            errors++;
            $display("FAIL reset_outputs got st=%b v=%0d m=%b s=%b w=%b exp st=0 v=0 m=001 s=100 w=0",
                     start_timer, Value, main_lights, side_lights, walk);
        end
        Reset_Sync = 1'b1;
        tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (start_timer !== 1'b1 || Value !== 4'd6) begin
            errors++; $display("FAIL first_pulse got st=%b v=%0d exp st=1 v=6", start_timer, Value);
        end
        repeat (3) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_main_hold();
        clear_log();
        repeat (4) begin
            tick(1'b0, 1'b0, 1'b1);
            repeat (7) tick(1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (vals.size() != 4) begin errors++; $display("FAIL main_hold_pulses got %0d exp 4", vals.size()); end
        foreach (vals[i]) begin
            checks++;
            if (vals[i] != 6 || mains[i] !== 3'b001) begin
                errors++; $display("FAIL main_hold[%0d] got v=%0d m=%b exp v=6 m=001", i, vals[i], mains[i]);
            end
        end
    endtask

    task automatic test_sensor_cycle();
        int exp_v[7] = '{2, 1, 6, 3, 2, 1, 6};
        clear_log();
        repeat (7) expire(1'b1, 1'b0);
        checks++;
        if (vals.size() != 7) begin
            errors++; $display("FAIL sensor_cycle_len got %0d exp 7", vals.size());
        end else begin
            foreach (exp_v[i]) begin
                checks++;
                if (vals[i] != exp_v[i]) begin errors++; $display("FAIL sensor_cycle[%0d] got %0d exp %0d", i, vals[i], exp_v[i]); end
            end
            checks++;
            if (mains[0] !== 3'b010 || mains[1] !== 3'b100) begin
                errors++; $display("FAIL sensor_cycle_main got %b,%b exp 010,100", mains[0], mains[1]);
            end
            checks++;
            if (sides[2] !== 3'b001 || sides[3] !== 3'b001) begin
                errors++; $display("FAIL sensor_cycle_side got %b,%b exp 001,001", sides[2], sides[3]);
            end
        end
    endtask

    task automatic test_no_ext();
        repeat (3) expire(1'b1, 1'b0);
        clear_log();
        expire(1'b0, 1'b0);
        checks++;
        if (vals.size() != 1 || vals[0] != 2) begin
            errors++; $display("FAIL no_ext got n=%0d v=%0d exp n=1 v=2", vals.size(), vals.size() ? vals[0] : -1);
        end
        repeat (2) expire(1'b0, 1'b0);
    endtask

    task automatic test_walk();
        int         exp_v[$];
        logic       exp_w[$];
        logic [2:0] exp_s[$];
        if (WALK_EN) begin
            exp_v = '{2, 1, 5, 6}; exp_w = '{0, 0, 1, 0}; exp_s = '{3'b010, 3'b100, 3'b100, 3'b100};
        end else begin
            exp_v = '{2, 1, 6}; exp_w = '{0, 0, 0}; exp_s = '{3'b010, 3'b100, 3'b100};
        end
        repeat (3) expire(1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        repeat (2) tick(1'b0, 1'b0, 1'b0);
        clear_log();
        repeat (exp_v.size()) expire(1'b0, 1'b0);
        checks++;
        if (vals.size() != exp_v.size()) begin
            errors++; $display("FAIL walk_len got %0d exp %0d", vals.size(), exp_v.size());
        end else begin
            foreach (exp_v[i]) begin
                checks++;
                if (vals[i] != exp_v[i] || walks[i] !== exp_w[i] || sides[i] !== exp_s[i]) begin
                    errors++;
                    $display("FAIL walk_seq[%0d] got v=%0d w=%b s=%b exp v=%0d w=%b s=%b",
                             i, vals[i], walks[i], sides[i], exp_v[i], exp_w[i], exp_s[i]);
                end
            end
        end
    endtask

    task automatic test_expired_held();
        clear_log();
        repeat (6) tick(1'b0, 1'b0, 1'b1);
        checks++;
        if (vals.size() != 3) begin errors++; $display("FAIL expired_held_pulses got %0d exp 3", vals.size()); end
        repeat (2) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_async_reset();
        repeat (3) expire(1'b1, 1'b0);
        expire(1'b0, 1'b0);
        checks++;
        if (side_lights !== 3'b010) begin errors++; $display("FAIL reach_side_yellow got %b exp 010", side_lights); end
        #2;
        expired = 1'b1;
        Reset_Sync = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({start_timer, Value, main_lights, side_lights, walk} !== {1'b0, 4'd0, 3'b001, 3'b100, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got st=%b v=%0d m=%b s=%b w=%b exp st=0 v=0 m=001 s=100 w=0",
                     start_timer, Value, main_lights, side_lights, walk);
        end
        @(negedge clk);
        Reset_Sync = 1'b1;
        tick(1'b0, 1'b0, 1'b1);
        checks++;
        if (start_timer !== 1'b1 || Value !== 4'd6) begin
            errors++; $display("FAIL post_reset_pulse got st=%b v=%0d exp st=1 v=6", start_timer, Value);
        end
    endtask

    task automatic test_random();
        repeat (1500)
            tick(1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
    endtask

    initial begin
        test_reset();
        test_main_hold();
        test_sensor_cycle();
        test_no_ext();
        test_walk();
        test_expired_held();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
